// File: rtl/axi_burst_memory_pkg.sv
// rtl/axi_burst_memory_pkg.sv - shared types and address helpers for the AXI burst memory
package axi_burst_memory_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Address math is done at a fixed wide width; callers truncate to their bus width.
  typedef logic [63:0] addr_calc_t;

  function automatic addr_calc_t next_address(input addr_calc_t addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
    addr_calc_t step;
    addr_calc_t mask;
    step = addr_calc_t'(1) << size;
    mask = ((addr_calc_t'(len) + addr_calc_t'(1)) << size) - addr_calc_t'(1);
    case (burst)
      BURST_FIXED: next_address = addr;
      BURST_WRAP:  next_address = (addr & ~mask) | ((addr + step) & mask);
      default:     next_address = addr + step;
    endcase
  endfunction

  function automatic logic burst_invalid(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst, input int unsigned max_size);
    logic bad_wrap_len;
    bad_wrap_len = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    burst_invalid = (burst == 2'b11) || (32'(size) > max_size) ||
                    ((burst == BURST_WRAP) && bad_wrap_len);
  endfunction

endpackage

// File: rtl/axi_burst_memory_ram.sv
// rtl/axi_burst_memory_ram.sv - 1R1W RAM with byte-enable write and registered read-first port
module axi_burst_memory_ram #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int IdxWidth  = $clog2(Depth)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IdxWidth-1:0]    waddr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [DataWidth/8-1:0] wstrb,
  input  logic                   re,
  input  logic [IdxWidth-1:0]    raddr,
  output logic [DataWidth-1:0]   rdata
);

  logic [DataWidth-1:0] mem [Depth];

  // Non-blocking read and write in one block gives old data on a same-word collision.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_burst_memory.sv
// rtl/axi_burst_memory.sv - AXI4 subordinate serving FIXED/INCR/WRAP bursts from on-chip RAM
module axi_burst_memory
  import axi_burst_memory_pkg::*;
#(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 4,
  parameter int MemoryDepth        = 1024
) (
  input  logic                          clk,
  input  logic                          areset_n,
  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [3:0]                    awcache,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DataWidth-1:0]          wdata,
  input  logic [DataWidth/8-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [3:0]                    arcache,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int unsigned ByteLanes = DataWidth / 8;
  localparam int unsigned LaneBits  = $clog2(ByteLanes);
  localparam int          IdxWidth  = $clog2(MemoryDepth);
  localparam logic [AddressWidth-1:0] DepthWords = AddressWidth'(MemoryDepth);

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  function automatic logic [AddressWidth-1:0] advance(input logic [AddressWidth-1:0] a,
      input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    advance = AddressWidth'(next_address(addr_calc_t'(a), size, len, burst));
  endfunction

  function automatic logic out_of_range(input logic [AddressWidth-1:0] a);
    out_of_range = (a >> LaneBits) >= DepthWords;
  endfunction

  function automatic logic [IdxWidth-1:0] word_index(input logic [AddressWidth-1:0] a);
    word_index = IdxWidth'(a >> LaneBits);
  endfunction

  w_state_t                w_state;
  logic [AddressWidth-1:0] w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [2:0]              w_size;
  logic [1:0]              w_burst;
  logic                    w_bad, w_err;

  r_state_t                r_state;
  logic [AddressWidth-1:0] r_addr;
  logic [7:0]              r_len, r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic                    r_bad;

  logic                    w_beat_bad, ram_we, ar_hs, r_adv, ram_re;
  logic [AddressWidth-1:0] r_next;
  logic [IdxWidth-1:0]     ram_raddr;
  logic [DataWidth-1:0]    ram_rdata;

  assign w_beat_bad = w_bad || out_of_range(w_addr);
  assign ram_we     = (w_state == W_DATA) && wvalid && wready && !w_beat_bad;
  assign ar_hs      = (r_state == R_IDLE) && arvalid && arready;
  assign r_adv      = (r_state == R_DATA) && rvalid && rready && !rlast;
  assign r_next     = advance(r_addr, r_size, r_len, r_burst);
  // The RAM is fetched one beat ahead so each beat is ready the cycle after its handshake.
  assign ram_re     = ar_hs || r_adv;
  assign ram_raddr  = ar_hs ? word_index(araddr) : word_index(r_next);
  assign rdata      = (rvalid && rresp == RESP_OKAY) ? ram_rdata : '0;

  axi_burst_memory_ram #(
    .DataWidth(DataWidth),
    .Depth    (MemoryDepth),
    .IdxWidth (IdxWidth)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(word_index(w_addr)),
    .wdata(wdata),
    .wstrb(wstrb),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_bad   <= burst_invalid(awsize, awlen, awburst, LaneBits);
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            // A misplaced or missing wlast is folded into the burst response.
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_bad || !wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_err  <= w_err || w_beat_bad || wlast;
              w_addr <= advance(w_addr, w_size, w_len, w_burst);
              w_cnt  <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (ar_hs) begin
            arready <= 1'b0;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            r_bad   <= burst_invalid(arsize, arlen, arburst, LaneBits);
            rvalid  <= 1'b1;
            rlast   <= (arlen == 8'd0);
            rresp   <= (burst_invalid(arsize, arlen, arburst, LaneBits) || out_of_range(araddr))
                       ? RESP_SLVERR : RESP_OKAY;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_cnt  <= r_cnt + 8'd1;
              rlast  <= ((r_cnt + 8'd1) == r_len);
              rresp  <= (r_bad || out_of_range(r_next)) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_memory.sv
// tb/tb_axi_burst_memory.sv - directed scoreboard bench for axi_burst_memory
module tb_axi_burst_memory;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  logic        clk, areset_n;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;

  logic [31:0] wd[$];
  logic [31:0] exp_data[$];
  logic [1:0]  exp_resp[$];

  axi_burst_memory dut (
    .clk(clk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(1'b0), .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(1'b0), .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r);
    exp_data.push_back(d);
    exp_resp.push_back(r);
  endtask

  task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] strb, input int early, input logic [1:0] exp_b);
    int n;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_aw_timeout"}, 32'(n < 50), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = strb;
      wlast = (early >= 0) ? (i == early) : (i == int'(len));
      n = 0;
      while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check({tag, "_w_timeout"}, 32'(n), 32'd0);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_bresp"}, 32'(bresp), 32'(exp_b));
    check({tag, "_bid"}, 32'(bid), 32'(id));
    @(negedge clk);
    bready = 1'b0;
    wd.delete();
  endtask

  task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input bit toggle);
    int n, beats, cyc;
    bit stalled;
    logic [31:0] held, ed;
    logic [1:0] er;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ar_timeout"}, 32'(n < 50), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "_rvalid_next"}, 32'(rvalid), 32'd1);
    beats = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (beats <= int'(len) && cyc < 200) begin
      rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (rvalid === 1'b1) begin
        if (stalled) check({tag, "_stable"}, rdata, held);
        if (rready) begin
          ed = exp_data.pop_front();
          er = exp_resp.pop_front();
          check({tag, "_rdata"}, rdata, ed);
          check({tag, "_rresp"}, 32'(rresp), 32'(er));
          check({tag, "_rlast"}, 32'(rlast), 32'(beats == int'(len)));
          check({tag, "_rid"}, 32'(rid), 32'(id));
          beats++;
          stalled = 1'b0;
        end else begin
          held = rdata;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check({tag, "_beats"}, 32'(beats), 32'(int'(len) + 1));
    check({tag, "_rvalid_done"}, 32'(rvalid), 32'd0);
    check({tag, "_arready_idle"}, 32'(arready), 32'd1);
  endtask

  initial begin
    int n;
    areset_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_resp", 32'({bresp, rresp}), 32'd0);
    check("rst_ids", 32'({bid, rid}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    areset_n = 1'b1;

    wd = '{32'hDEADBEEF};
    axi_write("single_wr", 4'd1, 32'h10, 8'd0, 3'd2, INCR, 4'hF, -1, OKAY);
    push_exp(32'hDEADBEEF, OKAY);
    axi_read("single_rd", 4'd1, 32'h10, 8'd0, 3'd2, INCR, 1'b0);

    wd = '{32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333};
    axi_write("incr_wr", 4'd5, 32'h100, 8'd3, 3'd2, INCR, 4'hF, -1, OKAY);
    for (int i = 0; i < 4; i++) push_exp(32'hA0000000 + 32'h01111111 * i, OKAY);
    axi_read("incr_rd", 4'd5, 32'h100, 8'd3, 3'd2, INCR, 1'b1);

    wd = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
    axi_write("wrap_wr", 4'd2, 32'h108, 8'd3, 3'd2, WRAP, 4'hF, -1, OKAY);
    push_exp(32'hC2C2C2C2, OKAY); push_exp(32'hC3C3C3C3, OKAY);
    push_exp(32'hC0C0C0C0, OKAY); push_exp(32'hC1C1C1C1, OKAY);
    axi_read("wrap_chk_incr", 4'd3, 32'h100, 8'd3, 3'd2, INCR, 1'b0);
    push_exp(32'hC0C0C0C0, OKAY); push_exp(32'hC1C1C1C1, OKAY);
    push_exp(32'hC2C2C2C2, OKAY); push_exp(32'hC3C3C3C3, OKAY);
    axi_read("wrap_rd", 4'd4, 32'h108, 8'd3, 3'd2, WRAP, 1'b1);

    wd = '{32'hF0F0F0F0, 32'hF1F1F1F1, 32'hF2F2F2F2, 32'hF3F3F3F3};
    axi_write("fixed_wr", 4'd6, 32'h108, 8'd3, 3'd2, FIXED, 4'hF, -1, OKAY);
    push_exp(32'hF3F3F3F3, OKAY); push_exp(32'hF3F3F3F3, OKAY);
    axi_read("fixed_rd", 4'd6, 32'h108, 8'd1, 3'd2, FIXED, 1'b0);
    push_exp(32'hC1C1C1C1, OKAY);
    axi_read("fixed_nbr", 4'd6, 32'h10C, 8'd0, 3'd2, INCR, 1'b0);

    wd = '{32'h55AA55AA};
    axi_write("word0_wr", 4'd7, 32'h0, 8'd0, 3'd2, INCR, 4'hF, -1, OKAY);
    wd = '{32'h12345678};
    axi_write("oor_wr", 4'd8, 32'h1000, 8'd0, 3'd2, INCR, 4'hF, -1, SLVERR);
    push_exp(32'h0, SLVERR);
    axi_read("oor_rd", 4'd8, 32'h1000, 8'd0, 3'd2, INCR, 1'b0);
    push_exp(32'h55AA55AA, OKAY);
    axi_read("oor_nowrite", 4'd8, 32'h0, 8'd0, 3'd2, INCR, 1'b0);

    wd = '{32'h11223344};
    axi_write("byte_base", 4'd9, 32'h20, 8'd0, 3'd2, INCR, 4'hF, -1, OKAY);
    wd = '{32'h0000AB00};
    axi_write("byte_wr", 4'd9, 32'h20, 8'd0, 3'd2, INCR, 4'h2, -1, OKAY);
    push_exp(32'h1122AB44, OKAY);
    axi_read("byte_rd", 4'd9, 32'h20, 8'd0, 3'd2, INCR, 1'b0);

    wd = '{32'h1, 32'h2};
    axi_write("early_wlast", 4'd10, 32'h30, 8'd1, 3'd2, INCR, 4'hF, 0, SLVERR);
    wd = '{32'h1, 32'h2, 32'h3};
    axi_write("wrap_len2", 4'd11, 32'h40, 8'd2, 3'd2, WRAP, 4'hF, -1, SLVERR);
    push_exp(32'h0, SLVERR);
    axi_read("burst_rsvd", 4'd12, 32'h10, 8'd0, 3'd2, 2'b11, 1'b0);
    push_exp(32'h0, SLVERR);
    axi_read("size_big", 4'd13, 32'h10, 8'd0, 3'd3, INCR, 1'b0);

    @(negedge clk);
    arid = 4'd14; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    check("abort_rvalid_pre", 32'(rvalid), 32'd1);
    #2 areset_n = 1'b0;
    #1;
    check("abort_rvalid", 32'(rvalid), 32'd0);
    check("abort_rlast", 32'(rlast), 32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_arready", 32'(arready), 32'd1);
    check("abort_rvalid_post", 32'(rvalid), 32'd0);
    push_exp(32'hDEADBEEF, OKAY);
    axi_read("abort_ram", 4'd15, 32'h10, 8'd0, 3'd2, INCR, 1'b0);

    check("sb_drained", 32'(exp_data.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
